// File: rtl/dice_roll_reader.sv
// Dice roll reader: turns raw LFSR nibbles into an unbiased die face by rejection sampling.
// Results are presented as binary, BCD and two 7-segment digits.
//
// state   | meaning
// IDLE    | waiting for roll_req; outputs hold last result
// DRAW_LO | waiting for a nibble for value[3:0]
// DRAW_HI | waiting for a nibble whose bit 0 becomes value[4] (d20 only)
// CHECK   | accept, retry or fall back
// OUT     | one-cycle done pulse with freshly registered outputs
module dice_roll_reader #(
    parameter int MAX_RETRY = 15,
    parameter int RETRY_W   = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_rnd_in,
    input  logic       i_rnd_valid,
    input  logic       i_roll_req,
    input  logic [2:0] i_die_sel,
    output logic       o_busy,
    output logic       o_done,
    output logic [4:0] o_result,
    output logic [3:0] o_bcd_tens,
    output logic [3:0] o_bcd_ones,
    output logic [6:0] o_seg_tens,
    output logic [6:0] o_seg_ones,
    output logic       o_biased
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRAW_LO = 3'd1;
    localparam logic [2:0] S_DRAW_HI = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;

    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    logic [2:0]         r_state;
    logic [4:0]         r_n;
    logic [2:0]         r_w;
    logic [4:0]         r_value;
    logic [RETRY_W-1:0] r_retry;
    logic               r_done;
    logic [4:0]         r_result;
    logic [3:0]         r_bcd_tens;
    logic [3:0]         r_bcd_ones;
    logic [6:0]         r_seg_tens;
    logic [6:0]         r_seg_ones;
    logic               r_biased;

    logic [4:0] w_sel_n;
    logic [2:0] w_sel_w;
    logic [3:0] w_mask;
    logic       w_accept;
    logic       w_exhausted;
    logic [4:0] w_face;
    logic [3:0] w_tens;
    logic [4:0] w_ones_full;
    logic [3:0] w_ones;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Face count and draw width for the requested die; codes 6/7 fall back to d6.
    always_comb begin
        w_sel_n = 5'd6;
        w_sel_w = 3'd3;
        case (i_die_sel)
            3'd0: begin w_sel_n = 5'd4;  w_sel_w = 3'd2; end
            3'd1: begin w_sel_n = 5'd6;  w_sel_w = 3'd3; end
            3'd2: begin w_sel_n = 5'd8;  w_sel_w = 3'd3; end
            3'd3: begin w_sel_n = 5'd10; w_sel_w = 3'd4; end
            3'd4: begin w_sel_n = 5'd12; w_sel_w = 3'd4; end
            3'd5: begin w_sel_n = 5'd20; w_sel_w = 3'd5; end
            default: begin w_sel_n = 5'd6; w_sel_w = 3'd3; end
        endcase
    end

    always_comb begin
        w_mask = 4'hF;
        case (r_w)
            3'd2:    w_mask = 4'h3;
            3'd3:    w_mask = 4'h7;
            default: w_mask = 4'hF;
        endcase
    end

    // value < 2N always holds, so the fallback face stays within 1..N.
    always_comb begin
        w_accept    = (r_value < r_n);
        w_exhausted = (r_retry == RETRY_LIMIT);
        w_face      = w_accept ? (r_value + 5'd1) : (r_value - r_n + 5'd1);
        if (w_face >= 5'd20) begin
            w_tens      = 4'd2;
            w_ones_full = w_face - 5'd20;
        end else if (w_face >= 5'd10) begin
            w_tens      = 4'd1;
            w_ones_full = w_face - 5'd10;
        end else begin
            w_tens      = 4'd0;
            w_ones_full = w_face;
        end
        w_ones = w_ones_full[3:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_n        <= 5'd0;
            r_w        <= 3'd0;
            r_value    <= 5'd0;
            r_retry    <= '0;
            r_done     <= 1'b0;
            r_result   <= 5'd0;
            r_bcd_tens <= 4'd0;
            r_bcd_ones <= 4'd0;
            r_seg_tens <= 7'd0;
            r_seg_ones <= 7'd0;
            r_biased   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_roll_req) begin
                        r_n     <= w_sel_n;
                        r_w     <= w_sel_w;
                        r_retry <= '0;
                        r_state <= S_DRAW_LO;
                    end
                end
                S_DRAW_LO: begin
                    if (i_rnd_valid) begin
                        if (r_w == 3'd5) begin
                            r_value <= {1'b0, i_rnd_in};
                            r_state <= S_DRAW_HI;
                        end else begin
                            r_value <= {1'b0, i_rnd_in & w_mask};
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_DRAW_HI: begin
                    if (i_rnd_valid) begin
                        r_value[4] <= i_rnd_in[0];
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_accept || w_exhausted) begin
                        r_result   <= w_face;
                        r_bcd_tens <= w_tens;
                        r_bcd_ones <= w_ones;
                        r_seg_tens <= (w_tens == 4'd0) ? 7'h00 : seg7(w_tens);
                        r_seg_ones <= seg7(w_ones);
                        r_biased   <= ~w_accept;
                        r_done     <= 1'b1;
                        r_state    <= S_OUT;
                    end else begin
                        r_retry <= r_retry + 1'b1;
                        r_state <= S_DRAW_LO;
                    end
                end
                S_OUT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_result   = r_result;
    assign o_bcd_tens = r_bcd_tens;
    assign o_bcd_ones = r_bcd_ones;
    assign o_seg_tens = r_seg_tens;
    assign o_seg_ones = r_seg_ones;
    assign o_biased   = r_biased;

endmodule

// File: tb/tb_dice_roll_reader.sv
// Directed bench for dice_roll_reader; MAX_RETRY is reduced to 2 so the fallback path is reachable.
module tb_dice_roll_reader;

    logic       clk;
    logic       rst;
    logic [3:0] rnd_in;
    logic       rnd_valid;
    logic       roll_req;
    logic [2:0] die_sel;
    logic       busy;
    logic       done;
    logic [4:0] result;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;
    logic       biased;

    int n_total = 0;
    int n_bad   = 0;

    // Per-cycle stimulus schedule: index k applies at the k-th edge after the request edge.
    logic [3:0] s_nib [16];
    logic       s_vld [16];
    logic       s_req [16];
    logic [2:0] s_die_after;

    dice_roll_reader #(.MAX_RETRY(2), .RETRY_W(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rnd_in    (rnd_in),
        .i_rnd_valid (rnd_valid),
        .i_roll_req  (roll_req),
        .i_die_sel   (die_sel),
        .o_busy      (busy),
        .o_done      (done),
        .o_result    (result),
        .o_bcd_tens  (bcd_tens),
        .o_bcd_ones  (bcd_ones),
        .o_seg_tens  (seg_tens),
        .o_seg_ones  (seg_ones),
        .o_biased    (biased)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_sched(input logic [3:0] nib, input logic [2:0] die_after);
        for (int i = 0; i < 16; i++) begin
            s_nib[i] = nib;
            s_vld[i] = 1'b1;
            s_req[i] = 1'b0;
        end
        s_die_after = die_after;
    endtask

    // Latency counts the request edge as 1; 0 means no done within the budget.
    task automatic run_roll(input logic [2:0] die, output int lat);
        lat       = 0;
        die_sel   = die;
        roll_req  = 1'b1;
        rnd_in    = s_nib[0];
        rnd_valid = s_vld[0];
        @(posedge clk); #1;
        die_sel = s_die_after;
        for (int k = 1; k < 16 && lat == 0; k++) begin
            roll_req  = s_req[k];
            rnd_in    = s_nib[k];
            rnd_valid = s_vld[k];
            @(posedge clk); #1;
            if (done) lat = k + 1;
        end
        roll_req  = 1'b0;
        rnd_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input int lat, input int e_lat,
                             input logic [4:0] e_res, input logic [3:0] e_t, input logic [3:0] e_o,
                             input logic [6:0] e_st, input logic [6:0] e_so, input logic e_b);
        chk({tag, ".lat"}, lat, e_lat);
        chk({tag, ".result"}, result, e_res);
        chk({tag, ".tens"}, bcd_tens, e_t);
        chk({tag, ".ones"}, bcd_ones, e_o);
        chk({tag, ".seg_tens"}, seg_tens, e_st);
        chk({tag, ".seg_ones"}, seg_ones, e_so);
        chk({tag, ".biased"}, biased, e_b);
        chk({tag, ".busy_in_out"}, busy, 1);
        @(posedge clk); #1;
        chk({tag, ".done_one_cycle"}, done, 0);
        chk({tag, ".idle_after"}, busy, 0);
    endtask

    initial begin
        int lat;
        int n_done;
        rst       = 1'b1;
        rnd_in    = 4'h0;
        rnd_valid = 1'b0;
        roll_req  = 1'b0;
        die_sel   = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.result", result, 0);
        chk("rst.segs", {seg_tens, seg_ones}, 0);
        chk("rst.bcd", {bcd_tens, bcd_ones}, 0);
        chk("rst.biased", biased, 0);

        // d6 single draw; die_sel changed to d20 after acceptance must not matter
        clear_sched(4'h0, 3'd5);
        s_nib[1] = 4'h5;
        run_roll(3'd1, lat);
        check_out("d6_single", lat, 3, 5'd6, 4'd0, 4'd6, 7'h00, 7'h7D, 1'b0);

        // d6 with two rejects; F in CHECK slots must be ignored
        clear_sched(4'hF, 3'd1);
        s_nib[1] = 4'h6;
        s_nib[3] = 4'h7;
        s_nib[5] = 4'h2;
        run_roll(3'd1, lat);
        check_out("d6_retry", lat, 7, 5'd3, 4'd0, 4'd3, 7'h00, 7'h4F, 1'b0);

        // d20: low nibble 3, high bit 1 -> value 19
        clear_sched(4'h0, 3'd0);
        s_nib[1] = 4'h3;
        s_nib[2] = 4'h1;
        run_roll(3'd5, lat);
        check_out("d20", lat, 4, 5'd20, 4'd2, 4'd0, 7'h5B, 7'h3F, 1'b0);

        // d20 fallback: three draws of 31 -> 31-20+1 = 12
        clear_sched(4'hF, 3'd5);
        run_roll(3'd5, lat);
        check_out("fallback", lat, 10, 5'd12, 4'd1, 4'd2, 7'h06, 7'h5B, 1'b1);

        // d10 with five idle rnd_valid cycles and a request while busy
        clear_sched(4'h0, 3'd3);
        for (int k = 1; k <= 5; k++) s_vld[k] = 1'b0;
        s_nib[6] = 4'h9;
        s_req[3] = 1'b1;
        run_roll(3'd3, lat);
        check_out("d10_gaps", lat, 8, 5'd10, 4'd1, 4'd0, 7'h06, 7'h3F, 1'b0);
        n_done = 0;
        rnd_valid = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        rnd_valid = 1'b0;
        chk("d10_no_second_done", n_done, 0);

        // reset while waiting in DRAW_HI
        die_sel   = 3'd5;
        roll_req  = 1'b1;
        rnd_in    = 4'h3;
        rnd_valid = 1'b1;
        @(posedge clk); #1;
        roll_req = 1'b0;
        @(posedge clk); #1;
        rnd_valid = 1'b0;
        chk("midrst.busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.result", result, 0);
        chk("midrst.bcd", {bcd_tens, bcd_ones}, 0);
        chk("midrst.segs", {seg_tens, seg_ones}, 0);
        n_done    = 0;
        rnd_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        rnd_valid = 1'b0;
        chk("midrst.no_done", n_done, 0);

        // d4 after reset: E masked to 2 -> 3
        clear_sched(4'h0, 3'd0);
        s_nib[1] = 4'hE;
        run_roll(3'd0, lat);
        check_out("d4", lat, 3, 5'd3, 4'd0, 4'd3, 7'h00, 7'h4F, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
